uart_tx_fifo: RTL and testbench

Byte buffer and launch sequencer that sits directly upstream of the UART transmitter. Producers push bytes at clock rate; the block stores them in a circular FIFO and feeds them one at a time to the transmitter through its valid/busy/done handshake. This decouples bursty producers, such as command responders and telemetry formatters, from the slow serial line.

---
 rtl/uart_tx_fifo_if.sv | 27 ++
 rtl/uart_tx_fifo.sv | 96 +++++++++
 tb/tb_uart_tx_fifo.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Producer-side push port and transmitter-side valid/busy/done handshake for uart_tx_fifo.
// The FIFO itself uses the slave modport; the producer/transmitter side uses master.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    logic                     i_Wr_En;
    logic [7:0]               i_Wr_Byte;
    logic                     o_Full;
    logic                     o_Empty;
    logic [$clog2(DEPTH):0]   o_Count;
    logic                     o_Overflow;
    logic                     o_Idle;
    logic                     o_TX_Valid;
    logic [7:0]               o_TX_Byte;
    logic                     i_TX_Busy;
    logic                     i_TX_Done;

    modport slave (
        input  i_Wr_En, i_Wr_Byte, i_TX_Busy, i_TX_Done,
        output o_Full, o_Empty, o_Count, o_Overflow, o_Idle, o_TX_Valid, o_TX_Byte
    );

    modport master (
        output i_Wr_En, i_Wr_Byte, i_TX_Busy, i_TX_Done,
        input  o_Full, o_Empty, o_Count, o_Overflow, o_Idle, o_TX_Valid, o_TX_Byte
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO that launches one byte per transmitter frame; launch one edge after data is visible.
// Pushes while full are dropped with a one-cycle overflow pulse; launches stall while the transmitter is busy.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input logic           i_Clock,
    input logic           i_Rst_L,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1
    } state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q, overflow_q;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    state_t        state_q, state_d;
    logic          push, pop;

    // Full is the registered flag, so a pop in the same cycle never rescues a push.
    assign push = bus.i_Wr_En && !full_q;

    always_comb begin
        state_d    = state_q;
        tx_valid_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_q && !bus.i_TX_Busy) begin
                    pop        = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_byte_d  = mem_q[rd_ptr_q];
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.i_TX_Done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_ptr_d = wr_ptr_q + AW'(push);
    assign rd_ptr_d = rd_ptr_q + AW'(pop);
    assign count_d  = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_byte_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == CW'(DEPTH));
            empty_q    <= (count_d == '0);
            overflow_q <= bus.i_Wr_En && full_q;
            tx_valid_q <= tx_valid_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    // Storage needs no reset: contents are only visible through count-qualified reads.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.i_Wr_Byte;
        end
    end

    assign bus.o_Full     = full_q;
    assign bus.o_Empty    = empty_q;
    assign bus.o_Count    = count_q;
    assign bus.o_Overflow = overflow_q;
    assign bus.o_Idle     = empty_q && (state_q == S_IDLE);
    assign bus.o_TX_Valid = tx_valid_q;
    assign bus.o_TX_Byte  = tx_byte_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DEPTH=4) with a behavioural UART transmitter at 4 clocks per bit.
module tb_uart_tx_fifo;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;

    logic clk;
    logic rst_l;

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .i_Clock (clk),
        .i_Rst_L (rst_l),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural transmitter: start bit, 8 data bits LSB first, stop bit.
    logic       tx_active, tx_done_r, force_busy, serial;
    logic [9:0] tx_shreg;
    int         tx_bit, tx_clk;

    assign bus.i_TX_Busy = tx_active | force_busy;
    assign bus.i_TX_Done = tx_done_r;
    assign serial        = tx_active ? tx_shreg[tx_bit] : 1'b1;

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tx_active <= 1'b0;
            tx_done_r <= 1'b0;
            tx_shreg  <= '0;
            tx_bit    <= 0;
            tx_clk    <= 0;
        end else begin
            tx_done_r <= 1'b0;
            if (!tx_active) begin
                if (bus.o_TX_Valid) begin
                    tx_active <= 1'b1;
                    tx_shreg  <= {1'b1, bus.o_TX_Byte, 1'b0};
                    tx_bit    <= 0;
                    tx_clk    <= 0;
                end
            end else if (tx_clk == CPB - 1) begin
                tx_clk <= 0;
                if (tx_bit == 9) begin
                    tx_active <= 1'b0;
                    tx_done_r <= 1'b1;
                end else begin
                    tx_bit <= tx_bit + 1;
                end
            end else begin
                tx_clk <= tx_clk + 1;
            end
        end
    end

    // Launch monitor: records launched bytes and done-to-valid distance in cycles.
    int         cyc;
    logic [7:0] launched[$];
    int         gaps[$];
    int         last_done;
    bit         seen_done;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.i_TX_Done) begin
            last_done = cyc;
            seen_done = 1'b1;
        end
        if (bus.o_TX_Valid) begin
            launched.push_back(bus.o_TX_Byte);
            if (seen_done) gaps.push_back(cyc - last_done);
        end
    end

    int n_chk;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        launched.delete();
        gaps.delete();
        seen_done = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        bus.i_Wr_Byte = b;
        bus.i_Wr_En   = 1'b1;
        tick();
        bus.i_Wr_En   = 1'b0;
    endtask

    task automatic wait_launches(input int n, input int budget, input string tag);
        int i;
        i = 0;
        while (launched.size() < n && i < budget) begin
            tick();
            i++;
        end
        check(tag, launched.size(), n);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int i;
        i = 0;
        while (!bus.o_Idle && i < budget) begin
            tick();
            i++;
        end
        check(tag, bus.o_Idle, 1);
    endtask

    logic [9:0] exp_frame;
    logic [7:0] bval;
    int         exp_cnt[6];
    int         exp_full[6];
    int         exp_ovf[6];
    int         nxt;
    int         w;

    initial begin
        n_chk         = 0;
        n_err         = 0;
        rst_l         = 1'b0;
        force_busy    = 1'b0;
        bus.i_Wr_En   = 1'b0;
        bus.i_Wr_Byte = 8'h00;
        clear_mon();
        repeat (3) tick();

        check("rst_empty",    bus.o_Empty,    1);
        check("rst_full",     bus.o_Full,     0);
        check("rst_count",    bus.o_Count,    0);
        check("rst_valid",    bus.o_TX_Valid, 0);
        check("rst_byte",     bus.o_TX_Byte,  8'h00);
        check("rst_overflow", bus.o_Overflow, 0);
        check("rst_idle",     bus.o_Idle,     1);
        rst_l = 1'b1;
        repeat (2) tick();

        // Single byte: latency, one-cycle valid, serial framing.
        clear_mon();
        push(8'hA5);
        check("sb_count_after_push", bus.o_Count, 1);
        check("sb_empty_after_push", bus.o_Empty, 0);
        check("sb_valid_early",      bus.o_TX_Valid, 0);
        tick();
        check("sb_valid",            bus.o_TX_Valid, 1);
        check("sb_byte",             bus.o_TX_Byte, 8'hA5);
        check("sb_count_launched",   bus.o_Count, 0);
        check("sb_idle_in_wait",     bus.o_Idle, 0);
        tick();
        check("sb_valid_one_cycle",  bus.o_TX_Valid, 0);
        tick();
        tick();
        exp_frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            check($sformatf("sb_line_bit%0d", k), serial, exp_frame[k]);
            repeat (CPB) tick();
        end
        wait_idle(40, "sb_idle_after_done");
        check("sb_byte_held", bus.o_TX_Byte, 8'hA5);

        // Burst of four consecutive pushes.
        clear_mon();
        exp_cnt[0] = 1; exp_cnt[1] = 1; exp_cnt[2] = 2; exp_cnt[3] = 3;
        for (int i = 0; i < 4; i++) begin
            bus.i_Wr_Byte = 8'(i + 1);
            bus.i_Wr_En   = 1'b1;
            tick();
            check($sformatf("burst_count%0d", i), bus.o_Count, exp_cnt[i]);
        end
        bus.i_Wr_En = 1'b0;
        wait_launches(4, 400, "burst_launches");
        wait_idle(100, "burst_idle");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("burst_order%0d", i), launched[i], i + 1);
        end
        check("burst_gap_count", gaps.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("burst_gap%0d", i), gaps[i], 2);
        end

        // Full / overflow with the transmitter held busy.
        clear_mon();
        force_busy = 1'b1;
        exp_cnt  = '{1, 2, 3, 4, 4, 4};
        exp_full = '{0, 0, 0, 1, 1, 1};
        exp_ovf  = '{0, 0, 0, 0, 1, 1};
        for (int i = 0; i < 6; i++) begin
            bus.i_Wr_Byte = 8'(8'h31 + i);
            bus.i_Wr_En   = 1'b1;
            tick();
            check($sformatf("full_count%0d", i), bus.o_Count,    exp_cnt[i]);
            check($sformatf("full_flag%0d", i),  bus.o_Full,     exp_full[i]);
            check($sformatf("full_ovf%0d", i),   bus.o_Overflow, exp_ovf[i]);
        end
        bus.i_Wr_En = 1'b0;
        tick();
        check("full_ovf_cleared", bus.o_Overflow, 0);
        check("full_no_launch",   launched.size(), 0);
        force_busy = 1'b0;
        wait_launches(4, 400, "full_drain");
        wait_idle(100, "full_idle");
        repeat (10) tick();
        check("full_drain_total", launched.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("full_order%0d", i), launched[i], 8'h31 + i);
        end

        // Wrap-around: ten bytes through the four-entry ring.
        clear_mon();
        nxt = 0;
        for (int c = 0; c < 3000 && nxt < 10; c++) begin
            if (bus.o_Count <= 1) begin
                bus.i_Wr_Byte = 8'(8'h10 + nxt);
                bus.i_Wr_En   = 1'b1;
                nxt++;
            end else begin
                bus.i_Wr_En = 1'b0;
            end
            tick();
        end
        bus.i_Wr_En = 1'b0;
        check("wrap_all_pushed", nxt, 10);
        wait_launches(10, 1000, "wrap_launches");
        wait_idle(100, "wrap_idle");
        for (int i = 0; i < 10; i++) begin
            check($sformatf("wrap_order%0d", i), launched[i], 8'h10 + i);
        end

        // Simultaneous push and launch with two bytes stored.
        clear_mon();
        force_busy = 1'b1;
        push(8'h51);
        push(8'h52);
        check("sim_count_before", bus.o_Count, 2);
        force_busy    = 1'b0;
        bus.i_Wr_Byte = 8'h53;
        bus.i_Wr_En   = 1'b1;
        tick();
        bus.i_Wr_En = 1'b0;
        check("sim_count_same", bus.o_Count, 2);
        check("sim_valid",      bus.o_TX_Valid, 1);
        check("sim_oldest",     bus.o_TX_Byte, 8'h51);
        wait_launches(3, 400, "sim_launches");
        wait_idle(100, "sim_idle");
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sim_order%0d", i), launched[i], 8'h51 + i);
        end

        // Reset during data bit 3 with two bytes queued.
        clear_mon();
        push(8'h61);
        push(8'h62);
        push(8'h63);
        check("rstm_queued", bus.o_Count, 2);
        w = 0;
        while (!(tx_active && tx_bit == 4) && w < 200) begin
            tick();
            w++;
        end
        check("rstm_reached_bit3", tx_active && tx_bit == 4, 1);
        rst_l = 1'b0;
        #1;
        check("rstm_valid", bus.o_TX_Valid, 0);
        check("rstm_empty", bus.o_Empty, 1);
        check("rstm_count", bus.o_Count, 0);
        check("rstm_idle",  bus.o_Idle, 1);
        check("rstm_byte",  bus.o_TX_Byte, 8'h00);
        check("rstm_line",  serial, 1);
        repeat (2) tick();
        rst_l = 1'b1;
        clear_mon();
        repeat (30) tick();
        check("rstm_no_launch", launched.size(), 0);
        check("rstm_still_empty", bus.o_Empty, 1);
        push(8'h77);
        tick();
        check("rstm_new_valid", bus.o_TX_Valid, 1);
        bval = bus.o_TX_Byte;
        check("rstm_new_byte", bval, 8'h77);
        wait_idle(100, "rstm_new_idle");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
